// File: rtl/bbox_sample_iterator_if.sv
// Bundle between the bounding-box stage (R13) and the sample iterator (R14).
// The master side is the upstream/downstream environment; the slave side is the iterator.
interface bbox_sample_iterator_if #(
    parameter int SIGFIG = 24,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
);
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R13U;
    logic [1:0][1:0][SIGFIG-1:0]            box_R13S;
    logic                                   validTri_R13H;
    logic [3:0]                             subSample_RnnnnU;
    logic                                   halt_RnnnnL;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R14U;
    logic [1:0][SIGFIG-1:0]                 sample_R14S;
    logic                                   validSamp_R14H;

    modport master (
        output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
        input  halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );

    modport slave (
        input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
        output halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );
endinterface

// File: rtl/bbox_sample_iterator.sv
// Walks a triangle's pixel-snapped bounding box in subsample steps, one sample per cycle.
// Upstream is held (halt low) for the whole walk; box[i][0]=x, box[i][1]=y.
//
// state | meaning
// WAIT  | idle, halt high; accepts the next valid triangle
// TEST  | presenting one live sample per cycle, halt low
module bbox_sample_iterator #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input logic                 clk,
    input logic                 rst,
    bbox_sample_iterator_if.slave bus
);
    typedef enum logic {WAIT, TEST} state_t;

    localparam logic [SIGFIG-1:0] STEP_1X  = SIGFIG'(1) << RADIX;
    localparam logic [SIGFIG-1:0] STEP_4X  = SIGFIG'(1) << (RADIX-1);
    localparam logic [SIGFIG-1:0] STEP_16X = SIGFIG'(1) << (RADIX-2);
    localparam logic [SIGFIG-1:0] STEP_64X = SIGFIG'(1) << (RADIX-3);

    state_t state_q, state_d;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
    logic [COLORS-1:0][SIGFIG-1:0]          color_q, color_d;
    logic signed [SIGFIG-1:0] ll_x_q, ll_x_d, ur_x_q, ur_x_d, ur_y_q, ur_y_d;
    logic signed [SIGFIG-1:0] x_q, x_d, y_q, y_d;
    logic        [SIGFIG-1:0] step_q, step_d;
    logic                     valid_q, valid_d, halt_q, halt_d;

    logic signed [SIGFIG-1:0] in_ll_x, in_ll_y, in_ur_x, in_ur_y;
    logic        [SIGFIG-1:0] in_step;
    // Widened by one bit so a box edge near +max terminates instead of wrapping.
    logic signed [SIGFIG:0]   x_inc, y_inc, ur_x_ext, ur_y_ext;

    assign in_ll_x = $signed(bus.box_R13S[0][0]);
    assign in_ll_y = $signed(bus.box_R13S[0][1]);
    assign in_ur_x = $signed(bus.box_R13S[1][0]);
    assign in_ur_y = $signed(bus.box_R13S[1][1]);

    assign x_inc    = $signed({x_q[SIGFIG-1], x_q}) + $signed({1'b0, step_q});
    assign y_inc    = $signed({y_q[SIGFIG-1], y_q}) + $signed({1'b0, step_q});
    assign ur_x_ext = $signed({ur_x_q[SIGFIG-1], ur_x_q});
    assign ur_y_ext = $signed({ur_y_q[SIGFIG-1], ur_y_q});

    // Step decode from the MSAA select; anything not one-hot walks at pixel pitch.
    always_comb begin
        in_step = STEP_1X;
        case (bus.subSample_RnnnnU)
            4'b1000: in_step = STEP_1X;
            4'b0100: in_step = STEP_4X;
            4'b0010: in_step = STEP_16X;
            4'b0001: in_step = STEP_64X;
            default: in_step = STEP_1X;
        endcase
    end

    // Next-state, sample advance and registered output values.
    always_comb begin
        state_d = state_q;
        tri_d   = tri_q;
        color_d = color_q;
        ll_x_d  = ll_x_q;
        ur_x_d  = ur_x_q;
        ur_y_d  = ur_y_q;
        step_d  = step_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            WAIT: begin
                // An inverted box is consumed here without leaving WAIT.
                if (bus.validTri_R13H && (in_ll_x <= in_ur_x) && (in_ll_y <= in_ur_y)) begin
                    state_d = TEST;
                    tri_d   = bus.tri_R13S;
                    color_d = bus.color_R13U;
                    ll_x_d  = in_ll_x;
                    ur_x_d  = in_ur_x;
                    ur_y_d  = in_ur_y;
                    step_d  = in_step;
                    x_d     = in_ll_x;
                    y_d     = in_ll_y;
                end
            end
            TEST: begin
                if (x_inc <= ur_x_ext) begin
                    x_d = x_inc[SIGFIG-1:0];
                end else if (y_inc <= ur_y_ext) begin
                    x_d = ll_x_q;
                    y_d = y_inc[SIGFIG-1:0];
                end else begin
                    state_d = WAIT;
                end
            end
            default: state_d = WAIT;
        endcase
        valid_d = (state_d == TEST);
        halt_d  = (state_d == WAIT);
    end

    // State and datapath registers; reset abandons any walk in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WAIT;
            tri_q   <= '0;
            color_q <= '0;
            ll_x_q  <= '0;
            ur_x_q  <= '0;
            ur_y_q  <= '0;
            step_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            halt_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            tri_q   <= tri_d;
            color_q <= color_d;
            ll_x_q  <= ll_x_d;
            ur_x_q  <= ur_x_d;
            ur_y_q  <= ur_y_d;
            step_q  <= step_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            halt_q  <= halt_d;
        end
    end

    assign bus.tri_R14S       = tri_q;
    assign bus.color_R14U     = color_q;
    assign bus.sample_R14S[0] = x_q;
    assign bus.sample_R14S[1] = y_q;
    assign bus.validSamp_R14H = valid_q;
    assign bus.halt_RnnnnL    = halt_q;
endmodule

// File: tb/tb_bbox_sample_iterator.sv
// Directed bench for bbox_sample_iterator: inputs change and outputs are checked on negedge.
module tb_bbox_sample_iterator;
    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bbox_sample_iterator_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) bus ();

    bbox_sample_iterator #(
        .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [SIGFIG-1:0] v);
        return longint'($signed(v));
    endfunction

    task automatic present(input int llx, input int lly, input int urx, input int ury,
                           input logic [3:0] sub, input int tv);
        logic [31:0] t;
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++) begin
                t = 32'(tv + v * AXIS + a);
                bus.tri_R13S[v][a] = t[SIGFIG-1:0];
            end
        for (int c = 0; c < COLORS; c++) begin
            t = 32'(tv + 100 + c);
            bus.color_R13U[c] = t[SIGFIG-1:0];
        end
        t = 32'(llx); bus.box_R13S[0][0] = t[SIGFIG-1:0];
        t = 32'(lly); bus.box_R13S[0][1] = t[SIGFIG-1:0];
        t = 32'(urx); bus.box_R13S[1][0] = t[SIGFIG-1:0];
        t = 32'(ury); bus.box_R13S[1][1] = t[SIGFIG-1:0];
        bus.subSample_RnnnnU = sub;
        bus.validTri_R13H    = 1'b1;
    endtask

    // Called on the negedge holding the first sample; returns on the negedge of the WAIT cycle after the walk.
    task automatic expect_walk(input string tag, input int llx, input int lly, input int step,
                               input int nx, input int ny, input int tv);
        for (int j = 0; j < ny; j++)
            for (int i = 0; i < nx; i++) begin
                check({tag, " valid"}, longint'(bus.validSamp_R14H), 1);
                check({tag, " halt"},  longint'(bus.halt_RnnnnL), 0);
                check({tag, " x"},     sx(bus.sample_R14S[0]), longint'(llx + i * step));
                check({tag, " y"},     sx(bus.sample_R14S[1]), longint'(lly + j * step));
                check({tag, " tri"},   longint'(bus.tri_R14S[0][0]), longint'(tv));
                check({tag, " color"}, longint'(bus.color_R14U[2]), longint'(tv + 102));
                @(negedge clk);
            end
        check({tag, " end valid"}, longint'(bus.validSamp_R14H), 0);
        check({tag, " end halt"},  longint'(bus.halt_RnnnnL), 1);
    endtask

    task automatic run_box(input string tag, input int llx, input int lly, input int urx, input int ury,
                           input logic [3:0] sub, input int step, input int nx, input int ny, input int tv);
        present(llx, lly, urx, ury, sub, tv);
        @(negedge clk);
        bus.validTri_R13H = 1'b0;
        expect_walk(tag, llx, lly, step, nx, ny, tv);
    endtask

    initial begin
        rst = 1'b0;
        bus.tri_R13S         = '0;
        bus.color_R13U       = '0;
        bus.box_R13S         = '0;
        bus.validTri_R13H    = 1'b0;
        bus.subSample_RnnnnU = 4'b1000;
        #12;
        check("reset valid", longint'(bus.validSamp_R14H), 0);
        check("reset halt",  longint'(bus.halt_RnnnnL), 1);
        check("reset x",     sx(bus.sample_R14S[0]), 0);
        check("reset tri",   longint'(bus.tri_R14S[2][2]), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle halt", longint'(bus.halt_RnnnnL), 1);

        run_box("1x",   0,    0,     2048, 1024,  4'b1000, 1024, 3, 2, 16);
        run_box("4x",   1024, 1024,  2048, 1024,  4'b0100, 512,  3, 1, 32);
        run_box("64x",  0,    0,     256,  128,   4'b0001, 128,  3, 2, 48);
        run_box("16x",  0,    -256,  256,  0,     4'b0010, 256,  2, 2, 56);
        run_box("nohot", 0,   0,     1024, 0,     4'b0110, 1024, 2, 1, 64);
        run_box("point", 3072, -2048, 3072, -2048, 4'b1000, 1024, 1, 1, 80);

        // Inverted box: consumed, no samples, no halt, next triangle accepted straight after.
        present(2048, 0, 1024, 0, 4'b1000, 96);
        @(negedge clk);
        check("inv valid", longint'(bus.validSamp_R14H), 0);
        check("inv halt",  longint'(bus.halt_RnnnnL), 1);
        run_box("after inv", -1024, 0, 0, 0, 4'b1000, 1024, 2, 1, 112);

        // Back-to-back: B is held valid through A's walk and taken only in the WAIT cycle.
        present(0, 0, 1024, 0, 4'b1000, 128);
        @(negedge clk);
        present(5120, 2048, 5120, 3072, 4'b1000, 144);
        for (int i = 0; i < 2; i++) begin
            check("b2b A valid", longint'(bus.validSamp_R14H), 1);
            check("b2b A x",     sx(bus.sample_R14S[0]), longint'(i * 1024));
            check("b2b A tri",   longint'(bus.tri_R14S[0][0]), 128);
            @(negedge clk);
        end
        check("b2b gap valid", longint'(bus.validSamp_R14H), 0);
        check("b2b gap halt",  longint'(bus.halt_RnnnnL), 1);
        check("b2b gap tri",   longint'(bus.tri_R14S[0][0]), 128);
        @(negedge clk);
        bus.validTri_R13H = 1'b0;
        expect_walk("b2b B", 5120, 2048, 1024, 1, 2, 144);

        // Near +max: the x increment must not wrap negative.
        run_box("ovf", (1 << (SIGFIG-1)) - 2048, 0, (1 << (SIGFIG-1)) - 1024, 1024,
                4'b1000, 1024, 2, 2, 160);

        // Asynchronous reset on the third sample of a six-sample walk.
        present(0, 0, 2048, 1024, 4'b1000, 176);
        @(negedge clk);
        bus.validTri_R13H = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst walk x", sx(bus.sample_R14S[0]), longint'(i * 1024));
            if (i < 2) @(negedge clk);
        end
        #1 rst = 1'b0;
        #1;
        check("midrst valid", longint'(bus.validSamp_R14H), 0);
        check("midrst halt",  longint'(bus.halt_RnnnnL), 1);
        check("midrst x",     sx(bus.sample_R14S[0]), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("postrst valid", longint'(bus.validSamp_R14H), 0);
        run_box("postrst", 1024, 2048, 2048, 2048, 4'b1000, 1024, 2, 1, 192);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bbox_sample_iterator.md
Name: bbox_sample_iterator

Overview:
- Raster stage that walks a triangle's bounding box in subsample-sized steps and emits one sample location per cycle, together with the triangle and its color.
- Fed by the bounding-box stage (R13). Its output goes through the jitter/hash stage to the sample-test stage, which consumes `sample_R16S`, `validSamp_R16H`, `tri_R16S` and `color_R16U`.
- Output slice is R14.
- Stalls the upstream stage with a halt signal while a box is being walked.

Parameters:
- SIGFIG, 24: bits in color and position.
- RADIX, 10: fraction bits in position; one pixel = 1<<RADIX.
- VERTS, 3: vertices per triangle.
- AXIS, 3: axes per vertex (x,y,z).
- COLORS, 3: color channels.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low; asserted at 0.
- tri_R13S  in  VERTS x AXIS x SIGFIG signed  triangle vertices.
- color_R13U  in  COLORS x SIGFIG unsigned  triangle color.
- box_R13S  in  2 x 2 x SIGFIG signed  bounding box; [0]=lower-left (x,y), [1]=upper-right (x,y), pixel-snapped.
- validTri_R13H  in  1  triangle and box valid.
- subSample_RnnnnU  in  4  one-hot MSAA select: 1000=1x, 0100=4x, 0010=16x, 0001=64x.
- halt_RnnnnL  out  1  low = upstream must hold its R13 outputs; high = iterator can accept.
- tri_R14S  out  VERTS x AXIS x SIGFIG signed  latched triangle.
- color_R14U  out  COLORS x SIGFIG unsigned  latched color.
- sample_R14S  out  2 x SIGFIG signed  current sample (x,y).
- validSamp_R14H  out  1  sample_R14S is a live sample.

Behaviour:

Reset:
- While rst=0, all outputs and state are cleared.
- State = WAIT, validSamp_R14H=0, halt_RnnnnL=1, sample/tri/color = 0.
- Reset mid-walk abandons the triangle with no further samples.

Step size:
- Sampled from subSample_RnnnnU at acceptance only.
- 1000 -> 1<<RADIX; 0100 -> 1<<(RADIX-1); 0010 -> 1<<(RADIX-2); 0001 -> 1<<(RADIX-3).
- Any non-one-hot value is treated as 1000.

FSM state WAIT:
- halt_RnnnnL=1, validSamp_R14H=0.
- On validTri_R13H=1 with LL.x<=UR.x and LL.y<=UR.y:
  - Latch tri, color, box and step.
  - Load sample=LL.
  - Go to TEST.
- On validTri_R13H=1 with an inverted box (UR.x<LL.x or UR.y<LL.y): consume the triangle, emit nothing, stay in WAIT.

FSM state TEST:
- halt_RnnnnL=0, validSamp_R14H=1, current sample is presented.
- Next sample:
  - if x+step <= UR.x: x += step.
  - else if y+step <= UR.y: x = LL.x, y += step.
  - else: go to WAIT.
- validTri_R13H is ignored in TEST.

Latency and counts:
- Triangle accepted at edge N; first sample is valid in the cycle after edge N.
- Samples follow at one per cycle with no gaps.
- Sample count = (floor((UR.x-LL.x)/step)+1) * (floor((UR.y-LL.y)/step)+1).
- There is exactly one idle WAIT cycle between consecutive triangles.

Arithmetic:
- All compares are signed.
- x+step and y+step are computed in SIGFIG+1 bits, so a box edge near the maximum positive value terminates rather than wrapping.
- A single-point box (LL==UR) yields exactly one sample.

Outputs:
- All outputs are registered.
- tri_R14S and color_R14U are held constant for the whole walk.
- These outputs hold their last values in WAIT; consumers qualify on validSamp_R14H.

Test Plan:
- 1x walk: RADIX=10, box LL=(0,0), UR=(2048,1024), subSample=1000 -> 6 samples (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024) on consecutive cycles. halt_RnnnnL low for 6 cycles, then high; validSamp_R14H then drops.
- 4x walk: box LL=(1024,1024), UR=(2048,1024), subSample=0100 -> step 512, samples (1024,1024),(1536,1024),(2048,1024), then WAIT.
- Degenerate and inverted boxes:
  - LL=UR=(3072,-2048) -> exactly one sample.
  - LL.x=2048, UR.x=1024 -> zero samples, no halt, ready next cycle.
- Back-to-back triangles held valid across halt: second triangle is accepted only in the WAIT cycle after the first walk's last sample. tri_R14S changes only at that boundary; the second walk's first sample is valid in the cycle after that WAIT cycle.
- Overflow edge: UR.x=(1<<(SIGFIG-1))-1024, LL.x=UR.x-1024, 1x -> exactly 2 x-samples per row, no wrap to negative.
- Reset mid-walk: drive rst=0 on the 3rd sample of a 6-sample box -> validSamp_R14H=0 and halt_RnnnnL=1 immediately (asynchronous). After release, the iterator is in WAIT and the next triangle starts at its LL.
